seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Sequential controller around a Moore-style serial pattern detector.
- Accepts a valid/ready bit stream and matches it against a runtime-programmable pattern of 1..W_MAX bits, in overlapping or non-overlapping mode.
- Reports each match as a registered event carrying the stream index.
- Counts matches and stops at a programmable limit. Sits between a bit-serial source and a match-event consumer.

Parameters:
- W_MAX, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter and of cfg_limit.
- IDX_W, 16, width of the stream bit index.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_en  in  1  load cfg_* registers (honoured only in IDLE)
- cfg_pattern  in  W_MAX  pattern; bit cfg_len-1 is the earliest bit, bit 0 the latest
- cfg_len  in  $clog2(W_MAX+1)  pattern length
- cfg_overlap  in  1  1 = overlapping matches allowed
- cfg_limit  in  CNT_W  stop after this many matches; 0 = unlimited
- start  in  1  arm the detector (IDLE or DONE)
- abort  in  1  return to IDLE from any state
- in_val  in  1  input bit valid
- in_rdy  out  1  input bit accepted when in_val&in_rdy
- in_bit  in  1  serial data
- out_val  out  1  match event valid
- out_rdy  in  1  consumer accepts event
- out_idx  out  IDX_W  index of the bit that completed the match
- match_cnt  out  CNT_W  matches detected since last start
- busy  out  1  state is RUN or WAIT
- done  out  1  state is DONE
- cfg_err  out  1  sticky: last start had an illegal cfg_len

Behaviour:
- Reset (async, reset_n=0): state=IDLE. Config registers, history, fill, idx, match_cnt, out_val, out_idx and cfg_err all 0. Outputs follow immediately, without waiting for a clock edge.
- States: IDLE, RUN, WAIT, DONE. in_rdy=1 only in RUN. out_val=1 only in WAIT.
- IDLE:
  - cfg_en loads cfg_pattern, cfg_len, cfg_overlap and cfg_limit at the clock edge. cfg_en in any other state is ignored.
  - If start is high and the registered cfg_len is in 1..W_MAX: state goes to RUN. hist, fill, idx and match_cnt are cleared, and cfg_err is cleared.
  - If start is high and cfg_len is 0 or greater than W_MAX: cfg_err is set and the state stays IDLE.
  - When cfg_en and start are high in the same cycle, start uses the previously registered config.
- RUN, on each in_val&in_rdy:
  - hist <= {hist[W_MAX-2:0], in_bit}.
  - fill <= min(fill+1, W_MAX).
  - idx <= idx+1, wrapping modulo 2^IDX_W. The first accepted bit has index 0.
  - A match occurs when the updated fill >= cfg_len and the updated hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0].
- On a match, at the same edge:
  - out_idx <= index of the current bit.
  - match_cnt <= match_cnt+1, saturating at all-ones.
  - state -> WAIT.
  - If cfg_overlap=0, fill <= 0. History bits are kept, but the fill gate blocks them from matching.
- Match latency: out_val rises the cycle after the completing bit is accepted.
- WAIT:
  - out_val=1; out_idx and match_cnt are held stable; in_rdy=0.
  - On out_val&out_rdy: if cfg_limit != 0 and match_cnt == cfg_limit, state -> DONE; otherwise state -> RUN.
- DONE: done=1, in_rdy=0. start re-arms the detector exactly as from IDLE; config is retained.
- abort has priority over every other event in every state:
  - state -> IDLE and out_val drops the next cycle.
  - match_cnt and cfg_err are retained; history and fill are cleared.
- start while in RUN or WAIT is ignored.

Decomposition:
- Package seq_detect_pkg holds:
  - the state enum typedef (IDLE, RUN, WAIT, DONE);
  - default constants W_MAX_DEF, CNT_W_DEF, IDX_W_DEF;
  - a length typedef sized $clog2(W_MAX+1).
- One sub-module, seq_pattern_match: purely combinational. Takes hist, fill, cfg_pattern and cfg_len; returns match. The length-masked compare is isolated there. The controller holds all state.

Test Plan:
- Overlapping mode: cfg pattern=3'b101, len=3, overlap=1, limit=0; start; stream 1,0,1,0,1 with out_rdy=1 -> events with out_idx=2 and out_idx=4, match_cnt=2. Each out_val appears one cycle after its completing bit.
- Non-overlapping mode: same config but overlap=0; stream 1,0,1,0,1,1,0,1 -> events only at out_idx=2 and out_idx=7, match_cnt=2.
- Output backpressure: after the first match, hold out_rdy=0 for 3 cycles -> out_val stays 1, out_idx=2 stays stable, in_rdy=0, idx does not advance; releasing out_rdy returns the FSM to RUN.
- Limit and re-arm: limit=1, stream 1,0,1 -> after the handshake done=1, busy=0, in_rdy=0. start -> RUN with match_cnt=0, and the next 1,0,1 yields out_idx=2.
- Error and abort: cfg_len=0 then start -> cfg_err=1, state stays IDLE. abort asserted during WAIT -> out_val=0 the next cycle, state IDLE, in_rdy=0.
- Async reset: drive reset_n=0 mid-WAIT, between clock edges -> out_val, busy, match_cnt and cfg_err go to 0 immediately. After release, state is IDLE.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial pattern detector controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int W_MAX_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int IDX_W_DEF = 16;

  typedef logic [$clog2(W_MAX_DEF+1)-1:0] len_t;

  // A programmed length is usable only if it selects at least one pattern bit
  // and no more bits than the history register holds.
  function automatic logic len_is_legal(input int len, input int w_max);
    return (len >= 1) && (len <= w_max);
  endfunction

endpackage

// File: rtl/seq_pattern_match.sv
// Length-masked comparison of the bit history against the programmed pattern.
module seq_pattern_match
  import seq_detect_pkg::*;
#(
  parameter int W_MAX = W_MAX_DEF
) (
  input  logic [W_MAX-1:0]           hist,
  input  logic [$clog2(W_MAX+1)-1:0] fill,
  input  logic [W_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(W_MAX+1)-1:0] cfg_len,
  output logic                       match
);

  logic [W_MAX-1:0] mask;
  logic [W_MAX-1:0] diff;

  // Only the low cfg_len bits take part, and enough bits must have arrived.
  always_comb begin
    mask = '0;
    for (int i = 0; i < W_MAX; i++) begin
      mask[i] = (i < int'(cfg_len));
    end
    diff  = (hist ^ cfg_pattern) & mask;
    match = len_is_legal(int'(cfg_len), W_MAX) && (fill >= cfg_len) && (diff == '0);
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller around a serial pattern detector: stream intake, match events,
// match counting with a stop limit, and configuration handling.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int W_MAX = W_MAX_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_en,
  input  logic [W_MAX-1:0]           cfg_pattern,
  input  logic [$clog2(W_MAX+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic [CNT_W-1:0]           cfg_limit,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic                       in_bit,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [IDX_W-1:0]           out_idx,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int LEN_W = $clog2(W_MAX+1);
  localparam logic [LEN_W-1:0] W_MAX_L = LEN_W'(W_MAX);

  state_t             state;
  logic [W_MAX-1:0]   pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [CNT_W-1:0]   limit_q;
  logic [W_MAX-1:0]   hist;
  logic [LEN_W-1:0]   fill;
  logic [IDX_W-1:0]   idx;

  logic [W_MAX-1:0]   hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic [CNT_W-1:0]   cnt_next;
  logic               len_ok;
  logic               hit;

  // Candidate history/fill as they would look after accepting the current bit.
  always_comb begin
    hist_next = {hist[W_MAX-2:0], in_bit};
    fill_next = (fill >= W_MAX_L) ? W_MAX_L : fill + 1'b1;
    cnt_next  = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
    len_ok    = len_is_legal(int'(len_q), W_MAX);
  end

  seq_pattern_match #(
    .W_MAX(W_MAX)
  ) u_match (
    .hist        (hist_next),
    .fill        (fill_next),
    .cfg_pattern (pattern_q),
    .cfg_len     (len_q),
    .match       (hit)
  );

  assign in_rdy = (state == RUN);
  assign busy   = (state == RUN) || (state == WAIT);
  assign done   = (state == DONE);

  // Main FSM: abort wins everywhere, otherwise per-state intake and handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      limit_q   <= '0;
      hist      <= '0;
      fill      <= '0;
      idx       <= '0;
      match_cnt <= '0;
      out_val   <= 1'b0;
      out_idx   <= '0;
      cfg_err   <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      out_val <= 1'b0;
      hist    <= '0;
      fill    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_en) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            limit_q   <= cfg_limit;
          end
          if (start) begin
            if (len_ok) begin
              state     <= RUN;
              hist      <= '0;
              fill      <= '0;
              idx       <= '0;
              match_cnt <= '0;
              cfg_err   <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_val) begin
            hist <= hist_next;
            idx  <= idx + 1'b1;
            if (hit) begin
              fill      <= overlap_q ? fill_next : '0;
              out_idx   <= idx;
              match_cnt <= cnt_next;
              out_val   <= 1'b1;
              state     <= WAIT;
            end else begin
              fill <= fill_next;
            end
          end
        end
        WAIT: begin
          if (out_rdy) begin
            out_val <= 1'b0;
            if ((limit_q != '0) && (match_cnt == limit_q)) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        DONE: begin
          if (start) begin
            if (len_ok) begin
              state     <= RUN;
              hist      <= '0;
              fill      <= '0;
              idx       <= '0;
              match_cnt <= '0;
              cfg_err   <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;

  localparam int W_MAX = 8;
  localparam int CNT_W = 8;
  localparam int IDX_W = 16;

  logic                       clk;
  logic                       reset_n;
  logic                       cfg_en;
  logic [W_MAX-1:0]           cfg_pattern;
  logic [$clog2(W_MAX+1)-1:0] cfg_len;
  logic                       cfg_overlap;
  logic [CNT_W-1:0]           cfg_limit;
  logic                       start;
  logic                       abort;
  logic                       in_val;
  logic                       in_rdy;
  logic                       in_bit;
  logic                       out_val;
  logic                       out_rdy;
  logic [IDX_W-1:0]           out_idx;
  logic [CNT_W-1:0]           match_cnt;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  int vector_count;
  int miscompare_count;

  seq_detect_ctrl #(
    .W_MAX(W_MAX),
    .CNT_W(CNT_W),
    .IDX_W(IDX_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_en      (cfg_en),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
    .start       (start),
    .abort       (abort),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_bit      (in_bit),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_idx     (out_idx),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b);
    in_val = 1'b1;
    in_bit = b;
    tick();
    in_val = 1'b0;
  endtask

  task automatic configure(input logic [W_MAX-1:0] pat, input int len, input logic ovl, input int lim);
    cfg_en      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_overlap = ovl;
    cfg_limit   = 8'(lim);
    tick();
    cfg_en = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    vector_count     = 0;
    miscompare_count = 0;
    reset_n     = 1'b0;
    cfg_en      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cfg_limit   = '0;
    start       = 1'b0;
    abort       = 1'b0;
    in_val      = 1'b0;
    in_bit      = 1'b0;
    out_rdy     = 1'b1;
    #1;
    checkOutput("rst_out_val", 32'(out_val), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_in_rdy", 32'(in_rdy), 0);
    checkOutput("rst_match_cnt", 32'(match_cnt), 0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 0);
    #12;
    reset_n = 1'b1;
    tick();

    // Overlapping: 1,0,1,0,1 against 101 -> hits at 2 and 4
    configure(8'b101, 3, 1'b1, 0);
    pulseStart();
    checkOutput("ovl_busy", 32'(busy), 1);
    checkOutput("ovl_in_rdy", 32'(in_rdy), 1);
    applyStimulus(1'b1);
    checkOutput("ovl_no_early", 32'(out_val), 0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("ovl_val_a", 32'(out_val), 1);
    checkOutput("ovl_idx_a", 32'(out_idx), 2);
    checkOutput("ovl_cnt_a", 32'(match_cnt), 1);
    checkOutput("ovl_rdy_wait", 32'(in_rdy), 0);
    tick();
    checkOutput("ovl_val_drop", 32'(out_val), 0);
    checkOutput("ovl_back_run", 32'(in_rdy), 1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("ovl_val_b", 32'(out_val), 1);
    checkOutput("ovl_idx_b", 32'(out_idx), 4);
    checkOutput("ovl_cnt_b", 32'(match_cnt), 2);
    tick();

    // Non-overlapping: 1,0,1,0,1,1,0,1 -> hits at 2 and 7 only
    pulseAbort();
    checkOutput("abort_idle", 32'(busy), 0);
    configure(8'b101, 3, 1'b0, 0);
    pulseStart();
    checkOutput("novl_cnt_clr", 32'(match_cnt), 0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("novl_val_a", 32'(out_val), 1);
    checkOutput("novl_idx_a", 32'(out_idx), 2);
    tick();
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("novl_gate_idx4", 32'(out_val), 0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("novl_none_idx6", 32'(out_val), 0);
    applyStimulus(1'b1);
    checkOutput("novl_val_b", 32'(out_val), 1);
    checkOutput("novl_idx_b", 32'(out_idx), 7);
    checkOutput("novl_cnt_b", 32'(match_cnt), 2);
    tick();

    // Backpressure: hold out_rdy low for three cycles while bits are offered
    pulseAbort();
    configure(8'b101, 3, 1'b1, 0);
    pulseStart();
    out_rdy = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1;
      in_bit = 1'b1;
      tick();
      checkOutput("bp_val_hold", 32'(out_val), 1);
      checkOutput("bp_idx_hold", 32'(out_idx), 2);
      checkOutput("bp_in_rdy", 32'(in_rdy), 0);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    tick();
    checkOutput("bp_release_val", 32'(out_val), 0);
    checkOutput("bp_release_run", 32'(in_rdy), 1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("bp_val_next", 32'(out_val), 1);
    checkOutput("bp_idx_next", 32'(out_idx), 4);
    tick();

    // Limit of one match, then re-arm from DONE
    pulseAbort();
    configure(8'b101, 3, 1'b1, 1);
    pulseStart();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("lim_cnt", 32'(match_cnt), 1);
    tick();
    checkOutput("lim_done", 32'(done), 1);
    checkOutput("lim_busy", 32'(busy), 0);
    checkOutput("lim_in_rdy", 32'(in_rdy), 0);
    pulseStart();
    checkOutput("rearm_busy", 32'(busy), 1);
    checkOutput("rearm_cnt", 32'(match_cnt), 0);
    out_rdy = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("rearm_val", 32'(out_val), 1);
    checkOutput("rearm_idx", 32'(out_idx), 2);

    // Abort out of WAIT, then illegal length handling
    pulseAbort();
    checkOutput("abort_val", 32'(out_val), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_in_rdy", 32'(in_rdy), 0);
    checkOutput("abort_cnt_kept", 32'(match_cnt), 1);
    out_rdy = 1'b1;
    configure(8'b101, 0, 1'b1, 0);
    pulseStart();
    checkOutput("err_set", 32'(cfg_err), 1);
    checkOutput("err_idle", 32'(busy), 0);
    cfg_en      = 1'b1;
    cfg_len     = 4'd3;
    start       = 1'b1;
    tick();
    cfg_en = 1'b0;
    start  = 1'b0;
    checkOutput("err_old_cfg", 32'(cfg_err), 1);
    checkOutput("err_old_idle", 32'(busy), 0);
    pulseStart();
    checkOutput("err_clear", 32'(cfg_err), 0);
    checkOutput("err_run", 32'(busy), 1);

    // Asynchronous reset asserted mid-cycle during WAIT
    out_rdy = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("ar_pre_val", 32'(out_val), 1);
    checkOutput("ar_pre_cnt", 32'(match_cnt), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_val", 32'(out_val), 0);
    checkOutput("ar_busy", 32'(busy), 0);
    checkOutput("ar_cnt", 32'(match_cnt), 0);
    checkOutput("ar_cfg_err", 32'(cfg_err), 0);
    #1;
    reset_n = 1'b1;
    out_rdy = 1'b1;
    tick();
    checkOutput("ar_post_busy", 32'(busy), 0);
    checkOutput("ar_post_done", 32'(done), 0);
    checkOutput("ar_post_in_rdy", 32'(in_rdy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
